// File: rtl/control_unit_if.sv
// Control-unit bundle: sequencing inputs from the datapath side and every strobe the sequencer drives.
interface control_unit_if;
    logic        run;
    logic        mem_rdy;
    logic [31:0] ir;
    logic        PCout;
    logic        Zlowout;
    logic        Zhighout;
    logic        MDRout;
    logic        MARin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        LOin;
    logic        HIin;
    logic        IncPC;
    logic        Read;
    logic [15:0] reg_out_sel;
    logic [15:0] reg_in_sel;
    logic [4:0]  alu_op;
    logic        instr_done;
    logic        halted;

    modport master (
        input  run, mem_rdy, ir,
        output PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
               Yin, Zin, LOin, HIin, IncPC, Read, reg_out_sel, reg_in_sel,
               alu_op, instr_done, halted
    );

    modport slave (
        output run, mem_rdy, ir,
        input  PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
               Yin, Zin, LOin, HIin, IncPC, Read, reg_out_sel, reg_in_sel,
               alu_op, instr_done, halted
    );
endinterface

// File: rtl/control_unit.sv
// Moore sequencer for fetch + register-register ALU ops: one state per step, T1 stalls until mem_rdy.
// Unary 5, binary 6, mul/div 7 cycles from T0; illegal opcode parks in HALT until rst.
module control_unit (
    input  logic            clk,
    input  logic            rst,
    control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [1:0] {C_BIN, C_MULDIV, C_UNARY, C_ILLEGAL} op_class_t;

    state_t    state_q, state_d;
    op_class_t op_class;

    logic [4:0]  opcode;
    logic [15:0] ra_hot, rb_hot, rc_hot;
    logic        unused_ir_bits;

    assign opcode         = bus.ir[31:27];
    assign ra_hot         = 16'h0001 << bus.ir[26:23];
    assign rb_hot         = 16'h0001 << bus.ir[22:19];
    assign rc_hot         = 16'h0001 << bus.ir[18:15];
    assign unused_ir_bits = ^bus.ir[14:0];

    always_comb begin
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: op_class = C_BIN;
            5'b01110, 5'b01111:                     op_class = C_MULDIV;
            5'b10000, 5'b10001:                     op_class = C_UNARY;
            default:                                op_class = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.PCout       = 1'b0;
        bus.Zlowout     = 1'b0;
        bus.Zhighout    = 1'b0;
        bus.MDRout      = 1'b0;
        bus.MARin       = 1'b0;
        bus.PCin        = 1'b0;
        bus.MDRin       = 1'b0;
        bus.IRin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.Zin         = 1'b0;
        bus.LOin        = 1'b0;
        bus.HIin        = 1'b0;
        bus.IncPC       = 1'b0;
        bus.Read        = 1'b0;
        bus.reg_out_sel = 16'h0000;
        bus.reg_in_sel  = 16'h0000;
        bus.alu_op      = 5'b00000;
        bus.instr_done  = 1'b0;
        bus.halted      = 1'b0;

        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_d   = S_T1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_rdy) state_d = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                case (op_class)
                    C_BIN: begin
                        bus.reg_out_sel = rb_hot;
                        bus.Yin         = 1'b1;
                        state_d         = S_T4;
                    end
                    C_MULDIV: begin
                        bus.reg_out_sel = ra_hot;
                        bus.Yin         = 1'b1;
                        state_d         = S_T4;
                    end
                    C_UNARY: begin
                        bus.reg_out_sel = rb_hot;
                        bus.alu_op      = opcode;
                        bus.Zin         = 1'b1;
                        state_d         = S_T4;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_BIN: begin
                        bus.reg_out_sel = rc_hot;
                        bus.alu_op      = opcode;
                        bus.Zin         = 1'b1;
                        state_d         = S_T5;
                    end
                    C_MULDIV: begin
                        bus.reg_out_sel = rb_hot;
                        bus.alu_op      = opcode;
                        bus.Zin         = 1'b1;
                        state_d         = S_T5;
                    end
                    C_UNARY: begin
                        bus.Zlowout    = 1'b1;
                        bus.reg_in_sel = ra_hot;
                        bus.instr_done = 1'b1;
                        state_d        = bus.run ? S_T0 : S_IDLE;
                    end
                    // IR cannot legally change after T3; treat it as a fault
                    default: state_d = S_HALT;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_BIN: begin
                        bus.Zlowout    = 1'b1;
                        bus.reg_in_sel = ra_hot;
                        bus.instr_done = 1'b1;
                        state_d        = bus.run ? S_T0 : S_IDLE;
                    end
                    C_MULDIV: begin
                        bus.Zlowout = 1'b1;
                        bus.LOin    = 1'b1;
                        state_d     = S_T6;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_T6: begin
                bus.Zhighout   = 1'b1;
                bus.HIin       = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = bus.run ? S_T0 : S_IDLE;
            end
            S_HALT:  bus.halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench: per-instruction expected strobe sequences built from the opcode tables and checked every cycle.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_unit_if cu_if ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (cu_if)
    );

    typedef struct packed {
        logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
        logic Yin, Zin, LOin, HIin, IncPC, Read;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  op;
        logic        done;
        logic        halted;
    } cv_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_cnt = 0;
    int  exp_done = 0;
    cv_t exp_q[$];

    localparam logic [4:0] LEGAL_OPS [12] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
        5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cv_t sample();
        cv_t v;
        v.PCout = cu_if.PCout;   v.Zlowout = cu_if.Zlowout; v.Zhighout = cu_if.Zhighout;
        v.MDRout = cu_if.MDRout; v.MARin = cu_if.MARin;     v.PCin = cu_if.PCin;
        v.MDRin = cu_if.MDRin;   v.IRin = cu_if.IRin;       v.Yin = cu_if.Yin;
        v.Zin = cu_if.Zin;       v.LOin = cu_if.LOin;       v.HIin = cu_if.HIin;
        v.IncPC = cu_if.IncPC;   v.Read = cu_if.Read;
        v.rout = cu_if.reg_out_sel; v.rin = cu_if.reg_in_sel;
        v.op = cu_if.alu_op;     v.done = cu_if.instr_done; v.halted = cu_if.halted;
        return v;
    endfunction

    // 0 = binary, 1 = mul/div, 2 = unary, 3 = illegal
    function automatic int op_kind(input logic [4:0] op);
        if (op inside {[5'd3:5'd10]}) return 0;
        if (op inside {5'd14, 5'd15}) return 1;
        if (op inside {5'd16, 5'd17}) return 2;
        return 3;
    endfunction

    task automatic build(input logic [31:0] iv, input int waits);
        cv_t v;
        logic [4:0] op = iv[31:27];
        int ra = int'(iv[26:23]);
        int rb = int'(iv[22:19]);
        int rc = int'(iv[18:15]);
        exp_q.delete();
        v = '0; v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1; exp_q.push_back(v);
        for (int k = 0; k <= waits; k++) begin
            v = '0; v.Zlowout = 1; v.PCin = 1; v.Read = 1; v.MDRin = 1; exp_q.push_back(v);
        end
        v = '0; v.MDRout = 1; v.IRin = 1; exp_q.push_back(v);
        case (op_kind(op))
            0: begin
                v = '0; v.rout[rb] = 1; v.Yin = 1; exp_q.push_back(v);
                v = '0; v.rout[rc] = 1; v.op = op; v.Zin = 1; exp_q.push_back(v);
                v = '0; v.Zlowout = 1; v.rin[ra] = 1; v.done = 1; exp_q.push_back(v);
            end
            1: begin
                v = '0; v.rout[ra] = 1; v.Yin = 1; exp_q.push_back(v);
                v = '0; v.rout[rb] = 1; v.op = op; v.Zin = 1; exp_q.push_back(v);
                v = '0; v.Zlowout = 1; v.LOin = 1; exp_q.push_back(v);
                v = '0; v.Zhighout = 1; v.HIin = 1; v.done = 1; exp_q.push_back(v);
            end
            2: begin
                v = '0; v.rout[rb] = 1; v.op = op; v.Zin = 1; exp_q.push_back(v);
                v = '0; v.Zlowout = 1; v.rin[ra] = 1; v.done = 1; exp_q.push_back(v);
            end
            default: begin
                v = '0; exp_q.push_back(v);
                v = '0; v.halted = 1;
                repeat (4) exp_q.push_back(v);
            end
        endcase
    endtask

    // Caller guarantees the next observed cycle is T0.
    task automatic do_instr(input string name, input logic [31:0] iv, input int waits,
                            input logic run_end, input int abort_at);
        int  ncyc;
        logic aborted = 1'b0;
        build(iv, waits);
        ncyc = exp_q.size();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk($sformatf("%s.cyc%0d", name, i), 64'(sample()), 64'(exp_q[i]));
            if (i == 0) cu_if.ir = iv;
            if (i >= 1 && i <= waits + 1) cu_if.mem_rdy = (i == waits + 1);
            else                         cu_if.mem_rdy = 1'($urandom_range(0, 1));
            cu_if.run = (i == ncyc - 1) ? run_end : 1'($urandom_range(0, 1));
            if (i == abort_at) begin
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted && op_kind(iv[31:27]) != 3) exp_done++;
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s.idle%0d", name, i), 64'(sample()), 64'd0);
            cu_if.run = (i == n - 1);
            cu_if.mem_rdy = 1'($urandom_range(0, 1));
        end
    endtask

    always @(negedge clk) if (cu_if.instr_done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] iv;
        logic [4:0]  op;
        logic        re;

        rst = 1'b1;
        cu_if.run = 1'b1;
        cu_if.mem_rdy = 1'b0;
        cu_if.ir = 32'h0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset%0d", i), 64'(sample()), 64'd0);
        end
        rst = 1'b0;

        do_instr("and_r5_r2_r4", 32'h4A920000, 0, 1'b1, -1);
        do_instr("neg_wait3",    32'h82A00000, 3, 1'b1, -1);
        do_instr("mul_r2_r3",    32'h71180000, 0, 1'b0, -1);
        idle_cycles("after_mul", 2);

        do_instr("add_abort", 32'h19920000, 0, 1'b1, 4);
        @(negedge clk);
        chk("abort_idle", 64'(sample()), 64'd0);
        rst = 1'b0;
        cu_if.run = 1'b1;
        do_instr("add_after_abort", 32'h19920000, 1, 1'b1, -1);

        for (int n = 0; n < 40; n++) begin
            op = LEGAL_OPS[$urandom_range(0, 11)];
            iv = {op, 27'($urandom())};
            if ($urandom_range(0, 3) == 0) iv[22:19] = iv[26:23];
            if ($urandom_range(0, 3) == 0) iv[18:15] = iv[22:19];
            re = 1'($urandom_range(0, 3) != 0);
            do_instr($sformatf("rnd%0d", n), iv, $urandom_range(0, 3), re, -1);
            if (!re) idle_cycles($sformatf("rnd%0d", n), $urandom_range(1, 3));
        end

        do_instr("illegal", 32'hF8000000, 0, 1'b1, -1);
        rst = 1'b1;
        @(negedge clk);
        chk("halt_reset", 64'(sample()), 64'd0);
        rst = 1'b0;
        cu_if.run = 1'b1;
        do_instr("after_halt", 32'h8A200000, 0, 1'b0, -1);
        idle_cycles("end", 1);

        chk("done_count", 64'(done_cnt), 64'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
